// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP encoding, fetch FSM states
// and the {pc, instruction} record carried through the fetch buffer.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instruction} buffer with flush; the head reads as all-zero
// (NOP at pc 0) whenever the buffer is empty.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head_entry,
    output logic [1:0]   count
);

    fetch_entry_t slot [FIFO_DEPTH];
    logic         head_reg;
    logic         tail_reg;
    logic [1:0]   count_reg;
    logic         push_ok;
    logic         pop_ok;

    // Full buffer accepts a push only when the head leaves in the same cycle.
    assign pop_ok  = pop && !flush && (count_reg != 2'd0);
    assign push_ok = push && !flush && ((count_reg != 2'd2) || pop_ok);

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (push_ok && (tail_reg == 1'(gi))) begin
                    slot_reg <= push_entry;
                end
            end

            assign slot[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else if (flush) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            if (push_ok) begin
                tail_reg <= ~tail_reg;
            end
            if (pop_ok) begin
                head_reg <= ~head_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = (count_reg != 2'd0) ? slot[head_reg] : '0;
    assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, imem handshake, two-deep
// prefetch buffer feeding IF/ID, and branch redirect/flush.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    fetch_unit_if.master       bus,
    output logic [INSTR_W-1:0] if_instruction,
    output logic [XLEN-1:0]    if_pc,
    output logic               if_valid
);

    fetch_state_t    state_reg;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fpc_reg;
    logic [XLEN-1:0] fpc_next;
    logic            push;
    logic            pop;
    logic [1:0]      count;
    logic [1:0]      count_next;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign if_valid   = (count != 2'd0);
    assign pop        = if_valid && !stall && !redirect;
    // FETCH implies count < 2, so an accepted ack can always be buffered.
    assign push       = (state_reg == ST_FETCH) && bus.imem_ack && !redirect;
    assign push_entry = '{pc: fpc_reg, instr: bus.imem_rdata};

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            fpc_reg   <= RESET_PC;
        end else begin
            state_reg <= state_next;
            fpc_reg   <= fpc_next;
        end
    end

    always_comb begin
        fpc_next   = fpc_reg;
        state_next = state_reg;
        count_next = count;
        if (redirect) begin
            fpc_next   = word_align(redirect_pc);
            state_next = ST_FETCH;
        end else begin
            if (push) begin
                fpc_next = fpc_reg + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
            state_next = (count_next == 2'd2) ? ST_HOLD : ST_FETCH;
        end
    end

    // The request is masked while reset is held so no transaction starts in reset.
    assign bus.imem_req  = (state_reg == ST_FETCH) && !rst;
    assign bus.imem_addr = word_align(fpc_reg);

    assign if_instruction = (count != 2'd0) ? head_entry.instr : NOP;
    assign if_pc          = (count != 2'd0) ? head_entry.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: cycle-driven stimulus, a queue model of the prefetch
// buffer and a next-address predictor checked every cycle at the falling edge.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    sb_entry_t   sb_q [$];
    logic [31:0] exp_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check outputs at negedge, advance the model.
    task automatic cycle(input logic a, input logic s, input logic r, input logic [31:0] rp);
        logic exp_req;
        bus.imem_ack   = a;
        bus.imem_rdata = a ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;
        stall          = s;
        redirect       = r;
        redirect_pc    = rp;
        @(negedge clk);
        exp_req = (sb_q.size() < 2);
        check("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) begin
            check("imem_addr", bus.imem_addr, exp_addr);
        end
        check("if_valid", 32'(if_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("if_pc", if_pc, sb_q[0].pc);
            check("if_instruction", if_instruction, sb_q[0].instr);
        end else begin
            check("empty_pc", if_pc, 32'h0);
            check("empty_instruction", if_instruction, NOP);
        end
        if (r) begin
            $display("redirect to %h, %0d entries flushed", rp, sb_q.size());
            sb_q.delete();
            exp_addr = {rp[31:2], 2'b00};
        end else begin
            if (sb_q.size() != 0 && !s) begin
                $display("consume pc=%h instr=%h", sb_q[0].pc, sb_q[0].instr);
                void'(sb_q.pop_front());
            end
            if (exp_req && a) begin
                sb_q.push_back('{pc: exp_addr, instr: instr_of(exp_addr)});
                exp_addr = exp_addr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks that outputs clear immediately.
    task automatic apply_reset(input int hold);
        bus.imem_ack = 1'b0;
        stall        = 1'b0;
        redirect     = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_instruction", if_instruction, NOP);
        check("rst_if_pc", if_pc, 32'h0);
        $display("reset applied");
        sb_q.delete();
        exp_addr = RESET_PC;
        repeat (hold) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_addr       = RESET_PC;

        // Reset state, then streaming with ack tied high.
        #1;
        check("init_imem_req", 32'(bus.imem_req), 32'h0);
        check("init_if_valid", 32'(if_valid), 32'h0);
        check("init_if_instruction", if_instruction, NOP);
        check("init_if_pc", if_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall for five cycles: buffer fills, fetch holds, then drains in order.
        apply_reset(2);
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with a full buffer and ack high; ack data must be dropped.
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_1002);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while streaming, ack present in the redirect cycle.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_2000);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Three wait states on an empty buffer.
        apply_reset(1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Address wrap past the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset asserted while a request is waiting for its ack.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        apply_reset(2);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random ack, stall and redirect traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  in  1  IF/ID hold; head entry not consumed while high.
REQ-005 SHALL have port redirect  in  1  taken branch / flush request from EX.
REQ-006 SHALL have port redirect_pc  in  32  branch target address.
REQ-007 SHALL have port imem_req  out  1  instruction memory request valid.
REQ-008 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-009 SHALL have port imem_ack  in  1  memory accepts request and returns data this cycle.
REQ-010 SHALL have port imem_rdata  in  32  instruction word, valid when imem_ack high.
REQ-011 SHALL have port if_instruction  out  32  instruction to IF/ID register.
REQ-012 SHALL have port if_pc  out  32  address of if_instruction.
REQ-013 SHALL have port if_valid  out  1  if_instruction/if_pc hold a real fetched entry.

Function
REQ-014 SHALL keep fetch PC register fpc; imem_addr = {fpc[31:2],2'b00}.
REQ-015 SHALL buffer fetched {pc,instruction} pairs in a 2-entry FIFO (head, tail pointers, 2-bit count).
REQ-016 SHALL run FSM: FETCH (imem_req=1), HOLD (imem_req=0); FETCH->HOLD when count reaches 2, HOLD->FETCH when count falls below 2.
REQ-017 SHALL hold imem_req and imem_addr stable in FETCH until imem_ack; wait states of any length allowed.
REQ-018 SHALL on imem_ack without redirect push {fpc, imem_rdata} and set fpc = fpc + 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-019 SHALL drive if_instruction/if_pc from FIFO head combinationally; if_valid = (count != 0).
REQ-020 SHALL drive if_instruction = 32'h0 (NOP) and if_pc = 32'h0 when count == 0.
REQ-021 SHALL pop head on posedge when if_valid && !stall && !redirect.
REQ-022 SHALL on push and pop in same cycle keep count unchanged; push permitted when count == 2 only if pop occurs that cycle.
REQ-023 SHALL on redirect: clear FIFO (count=0), discard any imem_ack data that cycle, set fpc = {redirect_pc[31:2],2'b00}, enter FETCH next cycle.
REQ-024 SHALL give redirect priority over stall, push and pop.
REQ-025 SHALL present the first redirected-path request (imem_req=1, new address) in the cycle after redirect; minimum redirect-to-if_valid latency 1 cycle after that request is acked.
REQ-026 SHALL never push an entry with count == 2 and no pop (no overflow) and never pop with count == 0 (no underflow).

Reset
REQ-027 SHALL on rst: fpc = RESET_PC, count/pointers = 0, FSM = FETCH, FIFO contents = 0.
REQ-028 SHALL during rst drive imem_req=0, if_valid=0, if_instruction=0, if_pc=0; imem_req rises in first cycle after rst release.
REQ-029 SHALL abandon any outstanding request when rst asserts mid-transaction; no entry pushed.

Structure
REQ-030 SHALL place NOP encoding (32'h0), instruction width, and FSM state encoding in shared package cpu_pkg.
REQ-031 SHALL instantiate one sub-module fetch_fifo (2-entry, push/pop/flush, count output); FSM and PC logic stay in fetch_unit.

Verification
REQ-032 SHALL cover reset release with imem_ack tied high, no stall -> addresses 0,4,8,... on consecutive cycles, if_valid high from cycle 2.
REQ-033 SHALL cover stall held 5 cycles with ack high -> two pushes then imem_req=0 (HOLD), if_pc frozen at 0x0; release -> resumes in order, no loss/duplication.
REQ-034 SHALL cover redirect to 0x0000_1002 while FIFO full and ack high -> FIFO empties, ack data dropped, next imem_addr 0x0000_1000, next if_pc 0x1000.
REQ-035 SHALL cover imem_ack delayed 3 cycles -> imem_addr stable throughout, if_valid low with if_instruction=0 until ack.
REQ-036 SHALL cover fpc=0xFFFF_FFFC acked -> next imem_addr 0x0000_0000.
REQ-037 SHALL cover rst asserted mid-wait (req high, ack low) -> outputs reset immediately, restart from RESET_PC.
